// File: rtl/axis_cmd_fifo_if.sv
// AXI-Stream bundle shared by the command FIFO ports.
// Signals: tdata (payload), tvalid (beat strobe), tready (downstream accept).
//   master : drives tdata/tvalid, samples tready.
//   slave  : samples tdata/tvalid only; the upstream write bridge
//            has no backpressure, so tready is not part of this view.
interface axis_cmd_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (
        output tdata,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid
    );
endinterface

// File: rtl/axis_cmd_fifo.sv
// Command beat FIFO between the AXI-Lite write bridge and an AXI-Stream sink.
// Ports: aclk/aresetn (sync, active-low), s_axis (slave, no tready),
//   m_axis (master, first-word fall-through), fill_count, overflow,
//   drop_count (saturating), clear_overflow (pulse).
module axis_cmd_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_cmd_fifo_if.slave        s_axis,
    axis_cmd_fifo_if.master       m_axis,
    output logic [ADDR_WIDTH:0]   fill_count,
    output logic                  overflow,
    output logic [15:0]           drop_count,
    input  logic                  clear_overflow
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  ovf_q,    ovf_d;
    logic [15:0]           drop_q,   drop_d;

    logic full;
    logic empty;
    logic pop;
    logic push_req;
    logic accept;
    logic drop;

    // count is DEPTH exactly when its top bit is set
    assign full     = count_q[ADDR_WIDTH];
    assign empty    = (count_q == '0);
    assign pop      = ~empty & m_axis.tready;
    assign push_req = s_axis.tvalid;
    // a full FIFO still takes the beat when the head leaves this cycle
    assign accept   = push_req & (~full | pop);
    assign drop     = push_req & ~accept;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        drop_d   = drop_q;

        if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // a drop in the clearing cycle is still recorded as the first one
        if (drop) begin
            ovf_d = 1'b1;
            if (clear_overflow) begin
                drop_d = 16'd1;
            end else if (drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end else if (clear_overflow) begin
            ovf_d  = 1'b0;
            drop_d = 16'd0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= 16'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    // storage is not reset; reset cycles must not write it
    always_ff @(posedge aclk) begin
        if (aresetn && accept) begin
            mem_q[wr_ptr_q] <= s_axis.tdata;
        end
    end

    assign m_axis.tvalid = ~empty;
    assign m_axis.tdata  = mem_q[rd_ptr_q];

    assign fill_count = count_q;
    assign overflow   = ovf_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_axis_cmd_fifo.sv
// Directed + scoreboard bench for axis_cmd_fifo.
// Drives at negedge, lets the posedge act, checks at the following negedge.
module tb_axis_cmd_fifo;

    localparam int DW    = 32;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          clear_overflow = 1'b0;
    logic [AW:0]   fill_count;
    logic          overflow;
    logic [15:0]   drop_count;

    axis_cmd_fifo_if #(.DATA_WIDTH(DW)) s_if ();
    axis_cmd_fifo_if #(.DATA_WIDTH(DW)) m_if ();

    axis_cmd_fifo #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .fill_count     (fill_count),
        .overflow       (overflow),
        .drop_count     (drop_count),
        .clear_overflow (clear_overflow)
    );

    always #5 aclk = ~aclk;

    int ncmp = 0;
    int nerr = 0;

    logic [DW-1:0] sb_q [$];
    logic          exp_ovf  = 1'b0;
    int            exp_drop = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check the outgoing beat, update the model.
    task automatic cycle(input logic tv, input logic [DW-1:0] d,
                         input logic tr, input logic clr);
        logic    exp_v;
        logic    do_pop;
        logic    acc;
        s_if.tvalid    = tv;
        s_if.tdata     = d;
        m_if.tready    = tr;
        clear_overflow = clr;
        #1;
        exp_v  = (sb_q.size() != 0);
        do_pop = exp_v && tr;
        chk("tvalid", {31'd0, m_if.tvalid}, {31'd0, exp_v});
        if (do_pop) begin
            chk("tdata", m_if.tdata, sb_q[0]);
            void'(sb_q.pop_front());
        end
        acc = tv && ((sb_q.size() < DEPTH) || do_pop);
        if (acc) begin
            sb_q.push_back(d);
        end
        if (tv && !acc) begin
            exp_ovf  = 1'b1;
            exp_drop = clr ? 1 : ((exp_drop == 16'hFFFF) ? exp_drop : exp_drop + 1);
        end else if (clr) begin
            exp_ovf  = 1'b0;
            exp_drop = 0;
        end
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic chk_status(input string tag);
        chk({tag, ".fill"}, {27'd0, fill_count}, sb_q.size());
        chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
        chk({tag, ".drop"}, {16'd0, drop_count}, exp_drop);
    endtask

    task automatic do_reset(input int n);
        aresetn        = 1'b0;
        s_if.tvalid    = 1'b1;
        s_if.tdata     = 32'hDEAD_BEEF;
        m_if.tready    = 1'b1;
        clear_overflow = 1'b0;
        repeat (n) begin
            @(posedge aclk);
            @(negedge aclk);
        end
        aresetn = 1'b1;
        s_if.tvalid = 1'b0;
        sb_q.delete();
        exp_ovf  = 1'b0;
        exp_drop = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * DEPTH && sb_q.size() != 0; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
        end
        chk("drain.empty", {31'd0, m_if.tvalid}, 32'd0);
        chk("drain.fill", {27'd0, fill_count}, 32'd0);
    endtask

    initial begin
        int pushed;
        s_if.tvalid = 1'b0;
        s_if.tdata  = '0;
        s_if.tready = 1'b0;
        m_if.tready = 1'b0;
        @(negedge aclk);

        // reset with upstream strobing
        do_reset(2);
        chk("rst.tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("rst.fill", {27'd0, fill_count}, 32'd0);
        chk("rst.ovf", {31'd0, overflow}, 32'd0);
        chk("rst.drop", {16'd0, drop_count}, 32'd0);

        // ordering
        cycle(1'b1, 32'h11, 1'b0, 1'b0);
        cycle(1'b1, 32'h22, 1'b0, 1'b0);
        cycle(1'b1, 32'h33, 1'b0, 1'b0);
        chk("ord.fill", {27'd0, fill_count}, 32'd3);
        chk("ord.head", m_if.tdata, 32'h11);
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b0);
        chk("ord.tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk("ord.fill0", {27'd0, fill_count}, 32'd0);

        // empty: push with tready high stores the beat, no pop
        cycle(1'b1, 32'h44, 1'b1, 1'b0);
        chk("emp.fill", {27'd0, fill_count}, 32'd1);
        chk("emp.head", m_if.tdata, 32'h44);
        drain();

        // overflow: 18 beats into 16 slots
        for (int i = 0; i < 18; i++) cycle(1'b1, i, 1'b0, 1'b0);
        chk("ovf.fill", {27'd0, fill_count}, 32'd16);
        chk("ovf.ovf", {31'd0, overflow}, 32'd1);
        chk("ovf.drop", {16'd0, drop_count}, 32'd2);

        // full with simultaneous pop: no drop
        cycle(1'b1, 32'hAA, 1'b1, 1'b0);
        chk("fullpop.fill", {27'd0, fill_count}, 32'd16);
        chk("fullpop.drop", {16'd0, drop_count}, 32'd2);
        drain();

        // clear race
        for (int i = 0; i < 19; i++) cycle(1'b1, 32'h100 + i, 1'b0, 1'b0);
        chk("clr.pre", {16'd0, drop_count}, 32'd5);
        cycle(1'b1, 32'h200, 1'b0, 1'b1);
        chk("clr.race.ovf", {31'd0, overflow}, 32'd1);
        chk("clr.race.drop", {16'd0, drop_count}, 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);
        chk("clr.ovf", {31'd0, overflow}, 32'd0);
        chk("clr.drop", {16'd0, drop_count}, 32'd0);
        drain();

        // wrap: 100 beats, random tready >= 75% duty
        pushed = 0;
        for (int i = 0; i < 400 && pushed < 100; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                cycle(1'b1, $urandom, $urandom_range(0, 3) != 0, 1'b0);
                pushed++;
            end else begin
                cycle(1'b0, '0, $urandom_range(0, 3) != 0, 1'b0);
            end
        end
        chk("wrap.pushed", pushed, 32'd100);
        chk_status("wrap");
        drain();

        // saturation
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, i, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) cycle(1'b1, 32'hF00D, 1'b0, 1'b0);
        chk("sat.drop", {16'd0, drop_count}, 32'hFFFF);
        chk("sat.ovf", {31'd0, overflow}, 32'd1);
        cycle(1'b1, 32'hF00D, 1'b0, 1'b0);
        chk("sat.hold", {16'd0, drop_count}, 32'hFFFF);
        chk_status("sat");

        // reset while full discards everything
        do_reset(1);
        chk("midrst.tvalid", {31'd0, m_if.tvalid}, 32'd0);
        chk_status("midrst");
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        chk("midrst.head", m_if.tdata, 32'h55);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
